// File: rtl/ui_param_ctrl.sv
// ui_param_ctrl: synchronised, debounced front-panel buttons edit NCH saturating parameter registers; UI_AUTOREPEAT_EN adds hold-to-repeat on up/down.
// Latency btn->params 2+DEB_CYC+1 cycles, all outputs registered; no backpressure, every accepted edit lands on the next edge.
module ui_param_ctrl #(
  parameter int               NCH     = 5,
  parameter int               W       = 4,
  parameter logic [NCH*W-1:0] MAXV    = {NCH{W'(2**W-1)}},
  parameter logic [NCH*W-1:0] INIT    = '0,
  parameter int               DEB_CYC = 120000,
  parameter int               REP_DLY = 6000000,
  parameter int               REP_PER = 1200000
) (
  input  logic                     CLK12,
  input  logic                     rst_n,
  input  logic [3:0]               btn,
  output logic [$clog2(NCH)-1:0]   sel,
  output logic [NCH*W-1:0]         params,
  output logic                     upd,
  output logic [$clog2(NCH)-1:0]   upd_ch
);

  localparam int SW = $clog2(NCH);
  localparam int DW = $clog2(DEB_CYC) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NCH - 1);

  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    deb_q;
  logic [3:0]    deb_prev_q;
  logic [DW-1:0] deb_cnt_q [4];
  logic [3:0]    press;
  logic [1:0]    val_ev;

  // A level is accepted only after DEB_CYC consecutive differing samples.
  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_cnt_q[i] <= '0;
          deb_q[i]     <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

`ifdef UI_AUTOREPEAT_EN
  localparam int RW = $clog2((REP_DLY > REP_PER ? REP_DLY : REP_PER) + 1) + 1;
  localparam logic [RW-1:0] DLY_LOAD = RW'(REP_DLY > 0 ? REP_DLY - 1 : 0);
  localparam logic [RW-1:0] PER_LOAD = RW'(REP_PER > 0 ? REP_PER - 1 : 0);

  typedef enum logic [1:0] {RP_IDLE, RP_HELD, RP_REPEAT} rp_state_t;

  rp_state_t     rp_state_q [2];
  rp_state_t     rp_state_d [2];
  logic [RW-1:0] rp_cnt_q [2];
  logic [RW-1:0] rp_cnt_d [2];
  logic [1:0]    rp_fire;

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rp_state_q[i] <= RP_IDLE;
        rp_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rp_state_q[i] <= rp_state_d[i];
        rp_cnt_q[i]   <= rp_cnt_d[i];
      end
    end
  end

  // Counter holds cycles left until the next repeat; HELD waits REP_DLY, REPEAT waits REP_PER.
  always_comb begin
    rp_state_d = rp_state_q;
    rp_cnt_d   = rp_cnt_q;
    rp_fire    = '0;
    for (int i = 0; i < 2; i++) begin
      case (rp_state_q[i])
        RP_IDLE: begin
          if (press[i]) begin
            rp_state_d[i] = RP_HELD;
            rp_cnt_d[i]   = DLY_LOAD;
          end
        end
        default: begin
          if (!deb_q[i]) begin
            rp_state_d[i] = RP_IDLE;
            rp_cnt_d[i]   = '0;
          end else if (rp_cnt_q[i] == '0) begin
            rp_fire[i]    = 1'b1;
            rp_state_d[i] = RP_REPEAT;
            rp_cnt_d[i]   = PER_LOAD;
          end else begin
            rp_cnt_d[i] = rp_cnt_q[i] - 1'b1;
          end
        end
      endcase
    end
  end

  assign val_ev = press[1:0] | rp_fire;
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REP_DLY > REP_PER);
  assign val_ev = press[1:0];
`endif

  logic [NCH*W-1:0] params_q;
  logic [NCH*W-1:0] params_d;
  logic [SW-1:0]    sel_q;
  logic [SW-1:0]    sel_d;
  logic             upd_q;
  logic             upd_d;
  logic [SW-1:0]    upd_ch_q;
  logic             inc_ev;
  logic             dec_ev;
  logic             nxt_ev;
  logic             prv_ev;
  logic [W-1:0]     cur_val;
  logic [W-1:0]     cur_max;
  int               sel_base;

  // Opposing events in the same cycle cancel; the edit always targets the pre-move channel.
  always_comb begin
    inc_ev   = val_ev[0] & ~val_ev[1];
    dec_ev   = val_ev[1] & ~val_ev[0];
    nxt_ev   = press[2] & ~press[3];
    prv_ev   = press[3] & ~press[2];
    sel_base = int'(sel_q) * W;
    cur_val  = params_q[sel_base +: W];
    cur_max  = MAXV[sel_base +: W];
    params_d = params_q;
    upd_d    = 1'b0;
    sel_d    = sel_q;
    if (inc_ev && (cur_val < cur_max)) begin
      params_d[sel_base +: W] = cur_val + 1'b1;
      upd_d = 1'b1;
    end else if (dec_ev && (cur_val != '0)) begin
      params_d[sel_base +: W] = cur_val - 1'b1;
      upd_d = 1'b1;
    end
    if (nxt_ev) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end else if (prv_ev) begin
      sel_d = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
    end
  end

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      params_q <= INIT;
      sel_q    <= '0;
      upd_q    <= 1'b0;
      upd_ch_q <= '0;
    end else begin
      params_q <= params_d;
      sel_q    <= sel_d;
      upd_q    <= upd_d;
      if (upd_d) upd_ch_q <= sel_q;
    end
  end

  assign params = params_q;
  assign sel    = sel_q;
  assign upd    = upd_q;
  assign upd_ch = upd_ch_q;

endmodule

// File: tb/tb_ui_param_ctrl.sv
// Bench for ui_param_ctrl: directed scenarios with literal expectations plus random button activity,
// all checked every cycle against a history-based behavioural model.
module tb_ui_param_ctrl;

  localparam int NCH  = 5;
  localparam int W    = 4;
  localparam int DEB  = 8;
  localparam int RDLY = 40;
  localparam int RPER = 10;

  logic             CLK12 = 1'b0;
  logic             rst_n;
  logic [3:0]       btn;
  logic [2:0]       sel;
  logic [NCH*W-1:0] params;
  logic             upd;
  logic [2:0]       upd_ch;

  always #5 CLK12 = ~CLK12;

  ui_param_ctrl #(
    .NCH(NCH), .W(W), .MAXV(20'hFF7FF), .INIT(20'h00000),
    .DEB_CYC(DEB), .REP_DLY(RDLY), .REP_PER(RPER)
  ) dut (
    .CLK12(CLK12), .rst_n(rst_n), .btn(btn), .sel(sel),
    .params(params), .upd(upd), .upd_ch(upd_ch)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pv(input int k);
    return int'(params[k*W +: W]);
  endfunction

  function automatic int maxv_of(input int k);
    return (k == 2) ? 7 : 15;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_val [NCH];
  int         m_sel;
  bit         m_upd;
  int         m_upd_ch;
  logic [3:0] raw_hist[$];
  logic [3:0] samp_hist[$];
  logic [3:0] lvl;
  logic [3:0] lvl_prev;
  int         press_edge [2];
  int         edge_no;

  function automatic bit rep_due(input int since);
    bit due;
    due = (since == RDLY) || (since > RDLY && ((since - RDLY) % RPER) == 0);
`ifndef UI_AUTOREPEAT_EN
    due = 1'b0;
`endif
    return due;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_val[k] = 0;
    m_sel = 0; m_upd = 1'b0; m_upd_ch = 0;
    raw_hist.delete(); samp_hist.delete();
    lvl = '0; lvl_prev = '0; edge_no = 0;
    press_edge[0] = 0; press_edge[1] = 0;
  endtask

  task automatic model_step();
    logic [3:0] ev, nl, sync_now;
    bit up, dn, flip;
    edge_no++;
    ev = lvl & ~lvl_prev;
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) press_edge[i] = edge_no;
      else if (lvl[i] && rep_due(edge_no - press_edge[i])) ev[i] = 1'b1;
    end
    up = ev[0] && !ev[1];
    dn = ev[1] && !ev[0];
    m_upd = 1'b0;
    if (up && m_val[m_sel] < maxv_of(m_sel)) begin
      m_val[m_sel]++; m_upd = 1'b1; m_upd_ch = m_sel;
    end else if (dn && m_val[m_sel] > 0) begin
      m_val[m_sel]--; m_upd = 1'b1; m_upd_ch = m_sel;
    end
    if (ev[2] && !ev[3]) m_sel = (m_sel + 1) % NCH;
    else if (ev[3] && !ev[2]) m_sel = (m_sel + NCH - 1) % NCH;
    // the debouncer sees the raw level from two edges ago
    sync_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 4'b0000;
    raw_hist.push_back(btn);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    samp_hist.push_back(sync_now);
    if (samp_hist.size() > DEB) void'(samp_hist.pop_front());
    nl = lvl;
    for (int b = 0; b < 4; b++) begin
      flip = (samp_hist.size() == DEB);
      for (int j = 0; j < samp_hist.size(); j++)
        if (samp_hist[j][b] == lvl[b]) flip = 1'b0;
      if (flip) nl[b] = ~lvl[b];
    end
    lvl_prev = lvl;
    lvl = nl;
  endtask

  always @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  int               cyc = 0;
  int               upd_cnt = 0;
  int               upd_cyc[$];
  logic [NCH*W-1:0] exp_p;

  always @(negedge CLK12) begin
    cyc++;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < NCH; k++) exp_p[k*W +: W] = W'(m_val[k]);
      chk("cyc_params", int'(params), int'(exp_p));
      chk("cyc_sel", int'(sel), m_sel);
      chk("cyc_upd", int'(upd), int'(m_upd));
      chk("cyc_upd_ch", int'(upd_ch), m_upd_ch);
      if (upd === 1'b1) begin
        upd_cnt++;
        upd_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    @(negedge CLK12);
    btn = btn | mask;
    repeat (hold) @(negedge CLK12);
    btn = btn & ~mask;
    repeat (gap) @(negedge CLK12);
  endtask

  int sel_exp [7] = '{1, 2, 3, 4, 0, 1, 2};
  int c0;
  int idx0;
  int n_rep;
  int exp_rep;
  int rem [4];
  bit got;

  initial begin
    rst_n = 1'b0;
    btn   = 4'b0000;
    repeat (3) @(negedge CLK12);
    chk("rst_params", int'(params), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_upd", int'(upd), 0);
    chk("rst_upd_ch", int'(upd_ch), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge CLK12);

    // first press latency: 2 sync + 8 debounce + 1 register
    btn[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK12);
      if (k == 10) chk("lat_before", pv(0), 0);
      if (k == 11) begin
        chk("lat_val", pv(0), 1);
        chk("lat_upd", int'(upd), 1);
        chk("lat_upd_ch", int'(upd_ch), 0);
        chk("lat_model", m_val[0], 1);
      end
      if (k == 12) chk("lat_strobe_len", int'(upd), 0);
    end
    btn[0] = 1'b0;
    repeat (20) @(negedge CLK12);
    press(4'b0001, 5, 30);
    chk("glitch_ignored", pv(0), 1);

    // channel navigation with wrap
    for (int i = 0; i < 7; i++) begin
      press(4'b0100, 12, 12);
      chk("sel_next", int'(sel), sel_exp[i]);
    end
    press(4'b1000, 12, 12);
    chk("sel_prev", int'(sel), 1);
    press(4'b0100, 12, 12);
    chk("sel_ch2", int'(sel), 2);

    // saturation on channel 2 (max 7)
    c0 = upd_cnt;
    repeat (9) press(4'b0001, 12, 12);
    chk("sat_hi_val", pv(2), 7);
    chk("sat_hi_upds", upd_cnt - c0, 7);
    c0 = upd_cnt;
    repeat (8) press(4'b0010, 12, 12);
    chk("sat_lo_val", pv(2), 0);
    chk("sat_lo_upds", upd_cnt - c0, 7);

    // up+down together cancel
    c0 = upd_cnt;
    press(4'b0011, 20, 20);
    chk("updn_val", pv(2), 0);
    chk("updn_upds", upd_cnt - c0, 0);
    press(4'b1000, 12, 12);
    press(4'b1000, 12, 12);
    chk("sel_back0", int'(sel), 0);

    // up+next together: edit lands on old channel, sel moves same edge
    @(negedge CLK12);
    btn = 4'b0101;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge CLK12);
      if (upd === 1'b1) begin
        got = 1'b1;
        chk("upnext_val", pv(0), 2);
        chk("upnext_sel", int'(sel), 1);
        chk("upnext_ch", int'(upd_ch), 0);
      end
    end
    if (!got) chk("upnext_timeout", 0, 1);
    btn = 4'b0000;
    repeat (20) @(negedge CLK12);

    // long hold on channel 1
    idx0 = upd_cyc.size();
    press(4'b0001, 100, 30);
    n_rep = upd_cyc.size() - idx0;
`ifdef UI_AUTOREPEAT_EN
    exp_rep = 7;
`else
    exp_rep = 1;
`endif
    chk("hold_val", pv(1), exp_rep);
    chk("hold_upds", n_rep, exp_rep);
    if (n_rep == exp_rep)
      for (int i = 1; i < n_rep; i++)
        chk("hold_spacing", upd_cyc[idx0+i] - upd_cyc[idx0], 30 + 10*i);

    // asynchronous reset mid-hold
    @(negedge CLK12);
    btn = 4'b0001;
    repeat (5) @(negedge CLK12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_params", int'(params), 0);
    chk("arst_sel", int'(sel), 0);
    chk("arst_upd", int'(upd), 0);
    chk("arst_upd_ch", int'(upd_ch), 0);
    chk("arst_model", m_val[1], 0);
    repeat (3) @(negedge CLK12);
    rst_n = 1'b1;
    c0 = upd_cnt;
    repeat (25) @(negedge CLK12);
    btn = 4'b0000;
    repeat (20) @(negedge CLK12);
    chk("held_thru_rst_upds", upd_cnt - c0, 1);
    chk("held_thru_rst_val", pv(0), 1);

    // random activity, model checked every cycle
    for (int b = 0; b < 4; b++) rem[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK12);
      for (int b = 0; b < 4; b++) begin
        if (rem[b] > 0) begin
          rem[b]--;
        end else if (btn[b]) begin
          btn[b] = 1'b0;
          rem[b] = int'($urandom_range(1, 40));
        end else begin
          btn[b] = 1'b1;
          rem[b] = int'($urandom_range(1, 70));
        end
      end
    end
    btn = 4'b0000;
    repeat (30) @(negedge CLK12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
